// File: rtl/rans_lane_scheduler.sv
// rans_lane_scheduler
//   Front end for a bank of NUM_STREAMS rANS encoder lanes sharing one clock.
//   Accepted symbols are dealt round-robin to the lanes through one-hot clock
//   enables. A lane-index pipeline remembers which lane owes a result
//   LANE_LAT cycles later. Returned bytes (0, 1 or 2 per result) are
//   serialised through an output byte FIFO. freq_wr_i / restart_i are
//   broadcast to all lanes and lock the input for NUM_STREAMS cycles.
//
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   in_valid_i/in_ready_o/symb_i  symbol input handshake
//   freq_wr_i, restart_i,
//   freq_i, cum_freq_i            configuration request (symb_i is the table address)
//   lane_ce_o, lane_symb_o        one-hot lane enable and symbol to the lanes
//   lane_freq_wr_o, lane_restart_o,
//   lane_cfg_o                    broadcast config {addr, freq, cum_freq}
//   lane_valid_i, lane_enc_i      per-lane result code and encoded bytes (lane k at slice k)
//   out_valid_o/out_ready_i/
//   out_byte_o                    output byte stream
//   error_o                       sticky: a lane returned the illegal code 2'b10
//   sym_cnt_o, byte_cnt_o         statistics
//
// Optional feature: define RANS_SCHED_STATS_EN to enable the accepted-symbol
// and popped-byte counters; otherwise both outputs are tied to zero.

module rans_lane_scheduler #(
  parameter int NUM_STREAMS  = 4,
  parameter int SYMBOL_WIDTH = 8,
  parameter int RESOLUTION   = 10,
  parameter int LANE_LAT     = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [SYMBOL_WIDTH-1:0]                symb_i,
  input  logic                                   freq_wr_i,
  input  logic                                   restart_i,
  input  logic [RESOLUTION-1:0]                  freq_i,
  input  logic [RESOLUTION-1:0]                  cum_freq_i,
  output logic [NUM_STREAMS-1:0]                 lane_ce_o,
  output logic [SYMBOL_WIDTH-1:0]                lane_symb_o,
  output logic                                   lane_freq_wr_o,
  output logic                                   lane_restart_o,
  output logic [SYMBOL_WIDTH+2*RESOLUTION-1:0]   lane_cfg_o,
  input  logic [2*NUM_STREAMS-1:0]               lane_valid_i,
  input  logic [2*SYMBOL_WIDTH*NUM_STREAMS-1:0]  lane_enc_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [SYMBOL_WIDTH-1:0]                out_byte_o,
  output logic                                   error_o,
  output logic [31:0]                            sym_cnt_o,
  output logic [31:0]                            byte_cnt_o
);

  localparam int LW      = $clog2(NUM_STREAMS);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int LKW     = $clog2(NUM_STREAMS + 1);
  // Worst case bytes that can still land after in_ready_o is seen high.
  localparam int RESERVE = 2 * (LANE_LAT + 2);

  logic [LW-1:0]  lane_ptr;
  logic [LKW-1:0] lock_cnt;
  logic           lock;
  logic           space_ok;
  logic           cfg_req;
  logic           accept;
  logic [CW-1:0]  fifo_cnt;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           pop;

  assign lock     = (lock_cnt != '0);
  assign space_ok = ((CW'(FIFO_DEPTH) - fifo_cnt) >= CW'(RESERVE));
  assign in_ready_o = rst_ni && !lock && space_ok;
  // Config has priority over a symbol presented in the same cycle.
  assign cfg_req  = rst_ni && !lock && (freq_wr_i || restart_i);
  assign accept   = in_valid_i && in_ready_o && !cfg_req;

  // ---- stage p0: dispatch to lanes / config broadcast ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lane_ptr       <= '0;
      lock_cnt       <= '0;
      lane_ce_o      <= '0;
      lane_freq_wr_o <= 1'b0;
      lane_restart_o <= 1'b0;
    end else begin
      lane_ce_o      <= accept ? ({{(NUM_STREAMS-1){1'b0}}, 1'b1} << lane_ptr) : '0;
      lane_freq_wr_o <= cfg_req && freq_wr_i;
      lane_restart_o <= cfg_req && restart_i;
      if (cfg_req)
        lock_cnt <= LKW'(NUM_STREAMS);
      else if (lock)
        lock_cnt <= lock_cnt - 1'b1;
      if (cfg_req && restart_i)
        lane_ptr <= '0;
      else if (accept)
        lane_ptr <= lane_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept)
      lane_symb_o <= symb_i;
    if (cfg_req)
      lane_cfg_o <= {symb_i, freq_i, cum_freq_i};
  end

  // ---- stages p0..pLANE_LAT: lane-index tracking until the result is due ----
  logic          vld_p [LANE_LAT+1];
  logic [LW-1:0] idx_p [LANE_LAT+1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k <= LANE_LAT; k++)
        vld_p[k] <= 1'b0;
    end else begin
      vld_p[0] <= accept;
      for (int k = 1; k <= LANE_LAT; k++)
        vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    idx_p[0] <= lane_ptr;
    for (int k = 1; k <= LANE_LAT; k++)
      idx_p[k] <= idx_p[k-1];
  end

  // ---- result capture: only the lane that owes a result is looked at ----
  logic [1:0]              sel_code;
  logic [2*SYMBOL_WIDTH-1:0] sel_enc;
  logic [1:0]              push_n;

  always_comb begin
    sel_code = 2'b00;
    sel_enc  = '0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      if (idx_p[LANE_LAT] == LW'(k)) begin
        sel_code = lane_valid_i[2*k +: 2];
        sel_enc  = lane_enc_i[2*SYMBOL_WIDTH*k +: 2*SYMBOL_WIDTH];
      end
    end
    if (!vld_p[LANE_LAT])
      sel_code = 2'b00;
  end

  assign push_n = (sel_code == 2'b11) ? 2'd2 :
                  (sel_code == 2'b01) ? 2'd1 : 2'd0;

  // ---- output byte FIFO ----
  logic [SYMBOL_WIDTH-1:0] mem [FIFO_DEPTH];

  assign out_valid_o = rst_ni && (fifo_cnt != '0);
  assign out_byte_o  = mem[rd_ptr];
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      error_o  <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push_n);
      rd_ptr   <= rd_ptr + AW'(pop);
      fifo_cnt <= fifo_cnt + CW'(push_n) - CW'(pop);
      if (sel_code == 2'b10)
        error_o <= 1'b1;
    end
  end

  // Low byte first, high byte in the following slot.
  always_ff @(posedge clk_i) begin
    if (push_n != 2'd0)
      mem[wr_ptr] <= sel_enc[SYMBOL_WIDTH-1:0];
    if (push_n == 2'd2)
      mem[wr_ptr + 1'b1] <= sel_enc[2*SYMBOL_WIDTH-1:SYMBOL_WIDTH];
  end

`ifdef RANS_SCHED_STATS_EN
  logic [31:0] sym_cnt;
  logic [31:0] byte_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || (cfg_req && restart_i)) begin
      sym_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      if (accept)
        sym_cnt <= sym_cnt + 32'd1;
      if (pop)
        byte_cnt <= byte_cnt + 32'd1;
    end
  end

  assign sym_cnt_o  = sym_cnt;
  assign byte_cnt_o = byte_cnt;
`else
  assign sym_cnt_o  = '0;
  assign byte_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rans_lane_scheduler.sv
// Testbench for rans_lane_scheduler: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_rans_lane_scheduler;

  localparam int NS  = 4;
  localparam int SW  = 8;
  localparam int RES = 10;
  localparam int LAT = 1;
  localparam int DEP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_ni;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [SW-1:0]          symb_i;
  logic                   freq_wr_i;
  logic                   restart_i;
  logic [RES-1:0]         freq_i;
  logic [RES-1:0]         cum_freq_i;
  logic [NS-1:0]          lane_ce_o;
  logic [SW-1:0]          lane_symb_o;
  logic                   lane_freq_wr_o;
  logic                   lane_restart_o;
  logic [SW+2*RES-1:0]    lane_cfg_o;
  logic [2*NS-1:0]        lane_valid_i;
  logic [2*SW*NS-1:0]     lane_enc_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [SW-1:0]          out_byte_o;
  logic                   error_o;
  logic [31:0]            sym_cnt_o;
  logic [31:0]            byte_cnt_o;

  rans_lane_scheduler #(
    .NUM_STREAMS(NS), .SYMBOL_WIDTH(SW), .RESOLUTION(RES),
    .LANE_LAT(LAT), .FIFO_DEPTH(DEP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .symb_i(symb_i),
    .freq_wr_i(freq_wr_i), .restart_i(restart_i), .freq_i(freq_i), .cum_freq_i(cum_freq_i),
    .lane_ce_o(lane_ce_o), .lane_symb_o(lane_symb_o),
    .lane_freq_wr_o(lane_freq_wr_o), .lane_restart_o(lane_restart_o), .lane_cfg_o(lane_cfg_o),
    .lane_valid_i(lane_valid_i), .lane_enc_i(lane_enc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_byte_o(out_byte_o),
    .error_o(error_o), .sym_cnt_o(sym_cnt_o), .byte_cnt_o(byte_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Lane behaviour, fixed per symbol value: {code[1:0], enc[15:0]}.
  function automatic logic [17:0] resp(input logic [7:0] s);
    if (s == 8'hEE) return {2'b11, 16'hBEEF};
    if (s == 8'hE0) return {2'b10, 16'h0000};
    case (s[7:6])
      2'b11:   return {2'b00, 16'h0000};
      2'b10:   return {2'b11, s ^ 8'h3C, s};
      default: return {2'b01, 8'hFF, s ^ 8'hA5};
    endcase
  endfunction

  // Lane models: answer LAT cycles after their enable; unrelated lanes carry noise.
  logic [NS-1:0]    rce  [LAT];
  logic [SW-1:0]    rsym [LAT];
  logic [2*NS-1:0]  noise_v;
  logic [2*SW*NS-1:0] noise_e;
  logic [17:0]      resp_w;

  always @(posedge clk) begin
    rce[0]  <= lane_ce_o;
    rsym[0] <= lane_symb_o;
    for (int i = 1; i < LAT; i++) begin
      rce[i]  <= rce[i-1];
      rsym[i] <= rsym[i-1];
    end
    noise_v <= 8'($urandom);
    noise_e <= {$urandom, $urandom};
  end

  assign resp_w = resp(rsym[LAT-1]);

  always_comb begin
    lane_valid_i = noise_v;
    lane_enc_i   = noise_e;
    for (int k = 0; k < NS; k++) begin
      if (rce[LAT-1][k] === 1'b1) begin
        lane_valid_i[2*k +: 2]   = resp_w[17:16];
        lane_enc_i[2*SW*k +: 2*SW] = resp_w[15:0];
      end
    end
  end

  // Reference model, evaluated mid-cycle.
  logic [7:0]  exp_q[$];
  logic [7:0]  popped[$];
  int          lane_m;
  int          lock_m;
  logic [NS-1:0] exp_ce;
  logic [SW-1:0] exp_sym;
  logic        exp_fw;
  logic        exp_rs;
  logic [31:0] syms_m;
  logic [31:0] bytes_m;

  always @(negedge clk) begin
    logic [17:0] r;
    logic cfg;
    logic acc;
    if (!rst_ni) begin
      exp_q.delete();
      lane_m = 0; lock_m = 0; exp_ce = '0; exp_fw = 1'b0; exp_rs = 1'b0;
      syms_m = '0; bytes_m = '0;
    end else begin
      check("lane_ce", 64'(lane_ce_o), 64'(exp_ce));
      if (exp_ce != '0) check("lane_symb", 64'(lane_symb_o), 64'(exp_sym));
      check("lane_freq_wr", 64'(lane_freq_wr_o), 64'(exp_fw));
      check("lane_restart", 64'(lane_restart_o), 64'(exp_rs));
`ifdef RANS_SCHED_STATS_EN
      check("sym_cnt", 64'(sym_cnt_o), 64'(syms_m));
      check("byte_cnt", 64'(byte_cnt_o), 64'(bytes_m));
`else
      check("sym_cnt", 64'(sym_cnt_o), 64'(0));
      check("byte_cnt", 64'(byte_cnt_o), 64'(0));
`endif
      if (lock_m != 0) check("lock_ready", 64'(in_ready_o), 64'(0));
      if (out_valid_o && out_ready_i) begin
        bytes_m = bytes_m + 32'd1;
        popped.push_back(out_byte_o);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_byte: got %0h, expected no byte", out_byte_o);
        end else begin
          check("out_byte", 64'(out_byte_o), 64'(exp_q.pop_front()));
        end
      end
      cfg = (freq_wr_i || restart_i) && (lock_m == 0);
      acc = in_valid_i && in_ready_o && !cfg;
      exp_fw = cfg && freq_wr_i;
      exp_rs = cfg && restart_i;
      if (lock_m != 0) lock_m--;
      if (cfg) lock_m = NS;
      if (exp_rs) begin
        lane_m = 0; syms_m = '0; bytes_m = '0;
      end
      if (acc) begin
        exp_ce  = NS'(1 << lane_m);
        exp_sym = symb_i;
        lane_m  = (lane_m + 1) % NS;
        syms_m  = syms_m + 32'd1;
        r = resp(symb_i);
        if (r[17:16] == 2'b01 || r[17:16] == 2'b11) exp_q.push_back(r[7:0]);
        if (r[17:16] == 2'b11) exp_q.push_back(r[15:8]);
      end else begin
        exp_ce = '0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [7:0] s);
    in_valid_i = 1'b1;
    symb_i     = s;
    tick();
    in_valid_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0]    s;
    logic [NS-1:0] ce;
    logic [7:0]    b;
  } vec_t;
  vec_t tab[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nacc;
    int first_low;
    logic [7:0] s;

    tab[0] = '{8'h00, 4'b0001, 8'hA5};
    tab[1] = '{8'h01, 4'b0010, 8'hA4};
    tab[2] = '{8'h02, 4'b0100, 8'hA7};
    tab[3] = '{8'h03, 4'b1000, 8'hA6};
    tab[4] = '{8'h04, 4'b0001, 8'hA1};
    tab[5] = '{8'h05, 4'b0010, 8'hA0};
    tab[6] = '{8'h06, 4'b0100, 8'hA3};
    tab[7] = '{8'h07, 4'b1000, 8'hA2};

    rst_ni = 1'b0; in_valid_i = 1'b0; symb_i = '0; freq_wr_i = 1'b0; restart_i = 1'b0;
    freq_i = '0; cum_freq_i = '0; out_ready_i = 1'b1;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready_o), 64'(0));
    check("rst_out_valid", 64'(out_valid_o), 64'(0));
    check("rst_lane_ce", 64'(lane_ce_o), 64'(0));
    check("rst_freq_wr", 64'(lane_freq_wr_o), 64'(0));
    check("rst_restart", 64'(lane_restart_o), 64'(0));
    check("rst_error", 64'(error_o), 64'(0));
    check("rst_sym_cnt", 64'(sym_cnt_o), 64'(0));
    check("rst_byte_cnt", 64'(byte_cnt_o), 64'(0));
    rst_ni = 1'b1;
    tick();

    // Round-robin dispatch, one-byte results, bytes in order.
    base = popped.size();
    for (int i = 0; i < 8; i++) begin
      in_valid_i = 1'b1;
      symb_i     = tab[i].s;
      tick();
      check("tab_ce", 64'(lane_ce_o), 64'(tab[i].ce));
      check("tab_symb", 64'(lane_symb_o), 64'(tab[i].s));
    end
    in_valid_i = 1'b0;
    repeat (6) tick();
    check("tab_nbytes", 64'(popped.size() - base), 64'(8));
    for (int i = 0; i < 8; i++)
      if (base + i < popped.size())
        check("tab_byte", 64'(popped[base+i]), 64'(tab[i].b));

    // Two-byte result: low byte then high byte.
    base = popped.size();
    send1(8'hEE);
    repeat (6) tick();
    check("beef_nbytes", 64'(popped.size() - base), 64'(2));
    if (popped.size() >= base + 2) begin
      check("beef_lo", 64'(popped[base]), 64'(8'hEF));
      check("beef_hi", 64'(popped[base+1]), 64'(8'hBE));
    end

    // freq_wr together with a symbol: config wins, 4-cycle lock.
    freq_wr_i = 1'b1; in_valid_i = 1'b1; symb_i = 8'h33;
    freq_i = 10'h155; cum_freq_i = 10'h0AA;
    tick();
    freq_wr_i = 1'b0; in_valid_i = 1'b0;
    check("cfg_freq_wr", 64'(lane_freq_wr_o), 64'(1));
    check("cfg_word", 64'(lane_cfg_o), 64'({8'h33, 10'h155, 10'h0AA}));
    check("cfg_no_ce", 64'(lane_ce_o), 64'(0));
    check("cfg_ready1", 64'(in_ready_o), 64'(0));
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    check("cfg_pulse_end", 64'(lane_freq_wr_o), 64'(0));
    check("cfg_ready2", 64'(in_ready_o), 64'(0));
    tick();
    check("lock_ignores_restart", 64'(lane_restart_o), 64'(0));
    check("cfg_ready3", 64'(in_ready_o), 64'(0));
    tick();
    check("cfg_ready4", 64'(in_ready_o), 64'(0));
    tick();
    check("cfg_ready_back", 64'(in_ready_o), 64'(1));
    send1(8'h40);
    check("after_cfg_lane", 64'(lane_ce_o), 64'(4'b0010));

    // Restart after three symbols: next symbol on lane 0.
    send1(8'h41); send1(8'h42); send1(8'h43);
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    check("restart_pulse", 64'(lane_restart_o), 64'(1));
    repeat (4) tick();
    send1(8'h44);
    check("restart_lane0", 64'(lane_ce_o), 64'(4'b0001));

    // Illegal code 10 sets a sticky error.
    check("error_before", 64'(error_o), 64'(0));
    send1(8'hE0);
    tick(); tick();
    check("error_set", 64'(error_o), 64'(1));
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    repeat (8) tick();
    check("error_sticky", 64'(error_o), 64'(1));

    // Back-pressure with two-byte results.
    out_ready_i = 1'b0;
    nacc = 0;
    first_low = -1;
    base = popped.size();
    for (int c = 0; c < 20; c++) begin
      in_valid_i = 1'b1;
      symb_i = 8'(8'h80 + c);
      if (in_ready_o) nacc++;
      else if (first_low < 0) first_low = c;
      tick();
    end
    in_valid_i = 1'b0;
    check("bp_accepted", 64'(nacc), 64'(8));
    check("bp_first_low", 64'(first_low), 64'(8));
    check("bp_full_ready", 64'(in_ready_o), 64'(0));
    check("bp_out_valid", 64'(out_valid_o), 64'(1));
    out_ready_i = 1'b1;
    repeat (24) tick();
    check("bp_nbytes", 64'(popped.size() - base), 64'(16));
    check("bp_drained", 64'(exp_q.size()), 64'(0));

    // Reset clears the sticky error.
    rst_ni = 1'b0;
    tick(); tick();
    check("error_cleared", 64'(error_o), 64'(0));
    rst_ni = 1'b1;
    tick();

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      in_valid_i = ($urandom_range(3) != 0);
      s = 8'($urandom);
      if (s == 8'hE0) s = 8'hE1;
      symb_i = s;
      freq_wr_i = ($urandom_range(39) == 0);
      restart_i = ($urandom_range(39) == 0);
      freq_i = 10'($urandom);
      cum_freq_i = 10'($urandom);
      out_ready_i = (c < 400) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      tick();
    end
    in_valid_i = 1'b0; freq_wr_i = 1'b0; restart_i = 1'b0; out_ready_i = 1'b1;
    repeat (30) tick();
    check("rand_drained", 64'(exp_q.size()), 64'(0));
    check("rand_no_error", 64'(error_o), 64'(0));

    // Reset in the middle of a stream.
    out_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) send1(8'(8'h10 + i));
    repeat (3) tick();
    check("prereset_valid", 64'(out_valid_o), 64'(1));
    rst_ni = 1'b0;
    tick();
    check("midrst_out_valid", 64'(out_valid_o), 64'(0));
    check("midrst_sym_cnt", 64'(sym_cnt_o), 64'(0));
    check("midrst_byte_cnt", 64'(byte_cnt_o), 64'(0));
    check("midrst_ce", 64'(lane_ce_o), 64'(0));
    tick();
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    tick();
    check("postrst_out_valid", 64'(out_valid_o), 64'(0));
    base = popped.size();
    send1(8'h05);
    check("postrst_lane0", 64'(lane_ce_o), 64'(4'b0001));
    repeat (5) tick();
    check("postrst_nbytes", 64'(popped.size() - base), 64'(1));
    if (popped.size() > base) check("postrst_byte", 64'(popped[base]), 64'(8'hA0));
    check("postrst_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rans_lane_scheduler.md
RANS_LANE_SCHEDULER -- requirements
Module: rans_lane_scheduler

Interface
REQ-001 SHALL have parameter NUM_STREAMS, default 4, number of rANS lanes (power of two, >=2).
REQ-002 SHALL have parameter SYMBOL_WIDTH, default 8, symbol and output byte width.
REQ-003 SHALL have parameter RESOLUTION, default 10, frequency width.
REQ-004 SHALL have parameter LANE_LAT, default 1, cycles from lane_ce_o to lane result.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, output byte FIFO depth (power of two, >=2*(LANE_LAT+2)).
REQ-006 SHALL have ports: clk_i  in  1  sole clock; rst_ni  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports: in_valid_i  in  1; in_ready_o  out  1; symb_i  in  SYMBOL_WIDTH  symbol (also freq table address).
REQ-008 SHALL have ports: freq_wr_i  in  1; restart_i  in  1; freq_i  in  RESOLUTION; cum_freq_i  in  RESOLUTION.
REQ-009 SHALL have ports: lane_ce_o  out  NUM_STREAMS  one-hot lane enable; lane_symb_o  out  SYMBOL_WIDTH.
REQ-010 SHALL have ports: lane_freq_wr_o  out  1; lane_restart_o  out  1; lane_cfg_o  out  SYMBOL_WIDTH+2*RESOLUTION  {addr,freq,cum_freq}.
REQ-011 SHALL have ports: lane_valid_i  in  2*NUM_STREAMS; lane_enc_i  in  2*SYMBOL_WIDTH*NUM_STREAMS  (lane k at slice k).
REQ-012 SHALL have ports: out_valid_o  out  1; out_ready_i  in  1; out_byte_o  out  SYMBOL_WIDTH; error_o  out  1.
REQ-013 SHALL have ports: sym_cnt_o  out  32; byte_cnt_o  out  32.

Function
REQ-014 SHALL replace gated clocks with per-lane clock enables; all logic on clk_i.
REQ-015 SHALL accept a symbol on in_valid_i && in_ready_o; accepted symbol n goes to lane (n mod NUM_STREAMS) since last restart.
REQ-016 SHALL, for a symbol accepted in cycle t, drive lane_ce_o one-hot for the selected lane and lane_symb_o in cycle t+1; lane_ce_o all-zero otherwise.
REQ-017 SHALL sample lane_valid_i/lane_enc_i of that lane in cycle t+1+LANE_LAT, tracked by a lane-index shift pipeline; other lanes ignored.
REQ-018 SHALL decode lane valid: 00 none; 01 push enc[SW-1:0]; 11 push enc[SW-1:0] then enc[2SW-1:SW]; 10 pushes nothing and sets error_o sticky.
REQ-019 SHALL present FIFO head on out_byte_o with out_valid_o; pop on out_valid_o && out_ready_i; first byte visible cycle after its push.
REQ-020 SHALL drive in_ready_o = !lock && (FIFO free slots >= 2*(LANE_LAT+2)); FIFO never overflows.
REQ-021 SHALL, on freq_wr_i or restart_i while not locked, register lane_freq_wr_o/lane_restart_o and lane_cfg_o for one cycle (broadcast) and set lock for NUM_STREAMS cycles.
REQ-022 SHALL ignore freq_wr_i/restart_i and in_valid_i during lock; simultaneous in_valid_i with freq_wr_i/restart_i: config wins, symbol not accepted.
REQ-023 SHALL, on restart, reset the lane pointer to lane 0; in-flight results still drain into the FIFO.
REQ-024 SHALL wrap the lane pointer NUM_STREAMS-1 -> 0 and FIFO pointers modulo FIFO_DEPTH; simultaneous push and pop at full/empty SHALL keep count correct.

Reset
REQ-025 SHALL, when rst_ni=0 at a clk_i edge, clear lane pointer, lock, pipeline, FIFO, error_o, counters; reset mid-operation discards in-flight data.
REQ-026 SHALL hold in reset: in_ready_o=0, out_valid_o=0, lane_ce_o=0, lane_freq_wr_o=0, lane_restart_o=0, error_o=0, sym_cnt_o=0, byte_cnt_o=0.

Configuration
REQ-027 SHALL, with RANS_SCHED_STATS_EN defined, count accepted symbols on sym_cnt_o and popped bytes on byte_cnt_o (32-bit, wrapping, cleared by restart).
REQ-028 SHALL, without RANS_SCHED_STATS_EN, tie sym_cnt_o and byte_cnt_o to 0 with no counter logic.

Verification
REQ-029 SHALL cover: 8 symbols, NUM_STREAMS=4, all lanes return 01 -> lane_ce_o sequence 0001,0010,0100,1000 repeated; 8 bytes out in order.
REQ-030 SHALL cover: lane returns 11 with enc=16'hBEEF -> out_byte_o 8'hEF then 8'hBE.
REQ-031 SHALL cover: freq_wr_i with in_valid_i same cycle -> lane_freq_wr_o pulse 1 cycle, in_ready_o low 4 cycles, symbol not accepted.
REQ-032 SHALL cover: out_ready_i=0, stream symbols with 11 returns -> in_ready_o drops once free <6; no byte lost after release.
REQ-033 SHALL cover: restart after 3 symbols -> next symbol on lane 0; lane valid 10 -> error_o=1 until reset.
REQ-034 SHALL cover: rst_ni low mid-stream -> out_valid_o=0, counters 0 next cycle.
